// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between NREQ requesters.
// Each access: grant, wait ROM_LAT edges, capture data, pulse rvalid to the winner.
module rom_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    output logic [NREQ-1:0]          gnt,
    output logic [DATA_W-1:0]        rdata,
    output logic [NREQ-1:0]          rvalid,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(ROM_LAT + 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     rvalid_q, rvalid_d;
    logic                busy_q, busy_d;
    logic [PTR_W-1:0]    sel_idx;
    logic [ADDR_W-1:0]   sel_addr;

    // Modulo-NREQ addition for pointer rotation (NREQ need not be a power of two).
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                  input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return PTR_W'(s);
    endfunction

    // First requester at or after the pointer; the descending scan lets the nearest win.
    always_comb begin
        sel_idx = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr_q, 32'(k))]) begin
                sel_idx = wrap_add(ptr_q, 32'(k));
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == PTR_W'(i)) begin
                sel_addr = addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            rdata_q    <= '0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        rdata_d    = rdata_q;
        gnt_d      = '0;
        rvalid_d   = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d      = sel_idx;
                    rom_addr_d = sel_addr;
                    gnt_d      = NREQ'(1) << sel_idx;
                    cnt_d      = CNT_W'(ROM_LAT);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // rom_addr is frozen here; data lands once the counter has run down.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rdata_d  = rom_data;
                    rvalid_d = NREQ'(1) << win_q;
                    ptr_d    = wrap_add(win_q, 32'd1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WAIT);
    end

    assign gnt      = gnt_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rom_addr = rom_addr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: scoreboard-checked LAT=1 instance plus a directed LAT=3 instance.
module tb_rom_arbiter;

    logic        clk;
    logic        rst_n;

    logic [1:0]  req;
    logic [9:0]  addr;
    logic [1:0]  gnt;
    logic [31:0] rdata;
    logic [1:0]  rvalid;
    logic [4:0]  rom_addr;
    logic [31:0] rom_data;
    logic        busy;

    logic [1:0]  b_req;
    logic [9:0]  b_addr;
    logic [1:0]  b_gnt;
    logic [31:0] b_rdata;
    logic [1:0]  b_rvalid;
    logic [4:0]  b_rom_addr;
    logic [31:0] b_rom_data;
    logic        b_busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct packed { logic [1:0] g; logic [4:0] a; } gnt_t;
    typedef struct packed { logic [1:0] v; logic [31:0] d; } rd_t;

    gnt_t gq[$];
    rd_t  rq[$];
    gnt_t ge;
    rd_t  re;
    int   gnt_cyc = 0;
    bit   outst = 1'b0;

    rom_arbiter #(.NREQ(2), .ADDR_W(5), .DATA_W(32), .ROM_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .gnt(gnt),
        .rdata(rdata), .rvalid(rvalid), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy)
    );

    rom_arbiter #(.NREQ(2), .ADDR_W(5), .DATA_W(32), .ROM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(b_req), .addr(b_addr), .gnt(b_gnt),
        .rdata(b_rdata), .rvalid(b_rvalid), .rom_addr(b_rom_addr),
        .rom_data(b_rom_data), .busy(b_busy)
    );

    // Synchronous ROM models: contents A5A5_0000 | address.
    logic [31:0] roma_q;
    logic [31:0] romb_q [3];
    always_ff @(posedge clk) begin
        roma_q    <= 32'hA5A5_0000 | 32'(rom_addr);
        romb_q[0] <= 32'hA5A5_0000 | 32'(b_rom_addr);
        romb_q[1] <= romb_q[0];
        romb_q[2] <= romb_q[1];
    end
    assign rom_data   = roma_q;
    assign b_rom_data = romb_q[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the LAT=1 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            outst = 1'b0;
        end else begin
            if (gnt != 2'b00) begin
                chk("gnt_while_outstanding", 32'(outst), 32'd0);
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 32'd0);
                end else begin
                    ge = gq.pop_front();
                    chk("gnt", 32'(gnt), 32'(ge.g));
                    chk("rom_addr", 32'(rom_addr), 32'(ge.a));
                end
                chk("busy_at_gnt", 32'(busy), 32'd1);
                outst   = 1'b1;
                gnt_cyc = cyc;
            end
            if (rvalid != 2'b00) begin
                chk("rvalid_latency", 32'(cyc - gnt_cyc), 32'd2);
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    re = rq.pop_front();
                    chk("rvalid", 32'(rvalid), 32'(re.v));
                    chk("rdata", rdata, re.d);
                end
                outst = 1'b0;
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        req    = 2'b00;
        addr   = '0;
        b_req  = 2'b00;
        b_addr = '0;

        step(2);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        rst_n = 1'b1;
        step(3);
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single read of address 3.
        addr[4:0] = 5'd3;
        req = 2'b01;
        gq.push_back('{g: 2'b01, a: 5'd3});
        rq.push_back('{v: 2'b01, d: 32'hA5A5_0003});
        step(1);
        chk("single_busy_c0", 32'(busy), 32'd1);
        req = 2'b00;
        step(1);
        chk("single_busy_c1", 32'(busy), 32'd1);
        step(1);
        chk("single_busy_c2", 32'(busy), 32'd0);
        chk("single_rvalid_c2", 32'(rvalid), 32'd1);
        step(2);

        // Reset while an access is in flight.
        addr[4:0] = 5'd4;
        req = 2'b01;
        gq.push_back('{g: 2'b01, a: 5'd4});
        step(1);
        req = 2'b00;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(5);

        // Both requesting continuously: grants alternate 0,1,0.
        addr = {5'd9, 5'd7};
        req  = 2'b11;
        gq.push_back('{g: 2'b01, a: 5'd7});
        gq.push_back('{g: 2'b10, a: 5'd9});
        gq.push_back('{g: 2'b01, a: 5'd7});
        rq.push_back('{v: 2'b01, d: 32'hA5A5_0007});
        rq.push_back('{v: 2'b10, d: 32'hA5A5_0009});
        rq.push_back('{v: 2'b01, d: 32'hA5A5_0007});
        step(7);
        req = 2'b00;
        step(4);

        // Requester 1 arrives while requester 0 is in flight.
        addr[4:0] = 5'd2;
        req = 2'b01;
        gq.push_back('{g: 2'b01, a: 5'd2});
        rq.push_back('{v: 2'b01, d: 32'hA5A5_0002});
        gq.push_back('{g: 2'b10, a: 5'd12});
        rq.push_back('{v: 2'b10, d: 32'hA5A5_000C});
        step(1);
        req = 2'b00;
        step(1);
        addr[9:5] = 5'd12;
        req = 2'b10;
        step(1);
        chk("wait_no_early_gnt", 32'(gnt), 32'd0);
        chk("wait_rvalid0", 32'(rvalid), 32'd1);
        step(1);
        chk("wait_gnt1", 32'(gnt), 32'd2);
        req = 2'b00;
        step(4);

        // Requester 1 withdraws before it could be granted.
        addr[4:0] = 5'd5;
        req = 2'b01;
        gq.push_back('{g: 2'b01, a: 5'd5});
        rq.push_back('{v: 2'b01, d: 32'hA5A5_0005});
        step(1);
        addr[9:5] = 5'd20;
        req = 2'b10;
        step(1);
        req = 2'b00;
        step(5);
        chk("withdraw_idle", 32'(busy), 32'd0);

        // Top address.
        addr[4:0] = 5'd31;
        req = 2'b01;
        gq.push_back('{g: 2'b01, a: 5'd31});
        rq.push_back('{v: 2'b01, d: 32'hA5A5_001F});
        step(1);
        chk("bound_rom_addr", 32'(rom_addr), 32'd31);
        req = 2'b00;
        step(4);

        // Top address on the ROM_LAT=3 instance: rvalid 4 edges after the grant edge.
        b_addr[4:0] = 5'd31;
        b_req = 2'b01;
        step(1);
        chk("lat3_gnt", 32'(b_gnt), 32'd1);
        chk("lat3_rom_addr", 32'(b_rom_addr), 32'd31);
        chk("lat3_busy_c0", 32'(b_busy), 32'd1);
        b_req = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            chk("lat3_no_early_rvalid", 32'(b_rvalid), 32'd0);
            chk("lat3_busy", 32'(b_busy), 32'd1);
        end
        step(1);
        chk("lat3_rvalid", 32'(b_rvalid), 32'd1);
        chk("lat3_rdata", b_rdata, 32'hA5A5_001F);
        chk("lat3_busy_done", 32'(b_busy), 32'd0);
        step(1);
        chk("lat3_rvalid_clear", 32'(b_rvalid), 32'd0);
        chk("lat3_rdata_hold", b_rdata, 32'hA5A5_001F);
        chk("lat3_no_regnt", 32'(b_gnt), 32'd0);

        step(2);
        chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
        chk("rd_queue_drained", 32'(rq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
